proc_gen: RTL

- Parametrised successor of the team's 16-bit multicycle bus processor.
- Data width and address width are generic. Fixed synchronous-memory wait cycles are replaced by a req/ready memory handshake.
- Adds registered condition flags (c, n, z), conditional branches, branch-and-link, and a debug register read port.
- Sits between the program/data memory and the board I/O wrapper; executes one 16-bit instruction at a time.

---
 rtl/proc_gen_pkg.sv | 52 +++++
 rtl/proc_gen_alu.sv | 32 +++
 rtl/proc_gen.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/proc_gen_pkg.sv
// rtl/proc_gen_pkg.sv - opcode, condition, FSM and bus-select encodings for proc_gen
package proc_gen_pkg;

   localparam logic [2:0] OP_MV    = 3'b000;
   localparam logic [2:0] OP_MVT_B = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_SUB   = 3'b011;
   localparam logic [2:0] OP_LD    = 3'b100;
   localparam logic [2:0] OP_ST    = 3'b101;
   localparam logic [2:0] OP_AND   = 3'b110;
   localparam logic [2:0] OP_RSV   = 3'b111;

   localparam logic [2:0] COND_AL = 3'd0;
   localparam logic [2:0] COND_EQ = 3'd1;
   localparam logic [2:0] COND_NE = 3'd2;
   localparam logic [2:0] COND_CC = 3'd3;
   localparam logic [2:0] COND_CS = 3'd4;
   localparam logic [2:0] COND_PL = 3'd5;
   localparam logic [2:0] COND_MI = 3'd6;
   localparam logic [2:0] COND_BL = 3'd7;

   typedef enum logic [2:0] {
      S_FETCH, S_FWAIT, S_EXEC1, S_EXEC2, S_EXEC3, S_MWAIT
   } state_e;

   typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND} alu_op_e;

   // Source selected onto the register-file write bus
   typedef enum logic [2:0] {WS_REG, WS_IMM, WS_MVT, WS_G, WS_DIN} wsel_e;

   function automatic logic cond_met(input logic [2:0] cond, input logic c, input logic n,
                                     input logic z);
      case (cond)
         COND_EQ: return z;
         COND_NE: return !z;
         COND_CC: return !c;
         COND_CS: return c;
         COND_PL: return !n;
         COND_MI: return n;
         default: return 1'b1;
      endcase
   endfunction

   function automatic alu_op_e alu_op_of(input logic [2:0] opc);
      case (opc)
         OP_ADD:  return ALU_ADD;
         OP_SUB:  return ALU_SUB;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/proc_gen_alu.sv
// rtl/proc_gen_alu.sv - combinational add/sub/and with carry, negative and zero outputs
module proc_gen_alu
   import proc_gen_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  alu_op_e           op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result,
   output logic              carry,
   output logic              neg,
   output logic              zero
);

   logic [DATA_W:0] wide;

   // Subtraction as a + ~b + 1 so the carry out is the no-borrow flag
   always_comb begin
      wide = '0;
      case (op)
         ALU_ADD: wide = {1'b0, a} + {1'b0, b};
         ALU_SUB: wide = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1);
         default: wide = {1'b0, a & b};
      endcase
      result = wide[DATA_W-1:0];
      carry  = wide[DATA_W];
      neg    = wide[DATA_W-1];
      zero   = (wide[DATA_W-1:0] == '0);
   end

endmodule

// File: rtl/proc_gen.sv
// rtl/proc_gen.sv - parametrised multicycle bus processor with req/ready memory handshake
module proc_gen
   import proc_gen_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 16,
   parameter int RESET_PC = 0
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Run,
   input  logic [DATA_W-1:0] DIN,
   input  logic              mem_ready,
   output logic              mem_req,
   output logic [ADDR_W-1:0] ADDR,
   output logic [DATA_W-1:0] DOUT,
   output logic              W,
   output logic              Done,
   output logic [2:0]        flags,
   input  logic [2:0]        dbg_sel,
   output logic [DATA_W-1:0] dbg_data
);

   logic [DATA_W-1:0] r [8];
   logic [DATA_W-1:0] a_q, g_q;
   logic [15:0]       ir;
   logic              c_q, n_q, z_q;
   state_e            state, next_state;

   logic [2:0]        opc, rx, ry;
   logic              imm_m, is_alu, br_taken;
   logic [DATA_W-1:0] imm, operand, wdata, alu_res;
   logic              alu_c, alu_n, alu_z;
   alu_op_e           alu_op;

   logic  ld_ir, ld_a, ld_g_alu, ld_g_br, wr_rx, wr_link, ld_flags;
   logic  pc_inc, pc_load_g, ld_addr_pc, ld_addr_ry, ld_dout, set_w, clr_w;
   wsel_e wsel;

   assign opc      = ir[15:13];
   assign imm_m    = ir[12];
   assign rx       = ir[11:9];
   assign ry       = ir[2:0];
   assign imm      = {{(DATA_W-9){ir[8]}}, ir[8:0]};
   assign operand  = imm_m ? imm : r[ry];
   assign is_alu   = (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND);
   assign alu_op   = alu_op_of(opc);
   assign br_taken = cond_met(rx, c_q, n_q, z_q);
   assign flags    = {c_q, n_q, z_q};
   assign dbg_data = r[dbg_sel];

   proc_gen_alu #(.DATA_W(DATA_W)) u_alu (
      .op     (alu_op),
      .a      (a_q),
      .b      (operand),
      .result (alu_res),
      .carry  (alu_c),
      .neg    (alu_n),
      .zero   (alu_z)
   );

   always_comb begin
      wdata = r[ry];
      case (wsel)
         WS_IMM:  wdata = imm;
         WS_MVT:  wdata = {ir[7:0], {(DATA_W-8){1'b0}}};
         WS_G:    wdata = g_q;
         WS_DIN:  wdata = DIN;
         default: wdata = r[ry];
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) state <= S_FETCH;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      Done       = 1'b0;
      mem_req    = (state == S_FWAIT) || (state == S_MWAIT);
      ld_ir      = 1'b0;
      ld_a       = 1'b0;
      ld_g_alu   = 1'b0;
      ld_g_br    = 1'b0;
      wr_rx      = 1'b0;
      wr_link    = 1'b0;
      wsel       = WS_REG;
      ld_flags   = 1'b0;
      pc_inc     = 1'b0;
      pc_load_g  = 1'b0;
      ld_addr_pc = 1'b0;
      ld_addr_ry = 1'b0;
      ld_dout    = 1'b0;
      set_w      = 1'b0;
      clr_w      = 1'b0;
      case (state)
         S_FETCH: if (Run) begin
            ld_addr_pc = 1'b1;
            pc_inc     = 1'b1;
            next_state = S_FWAIT;
         end
         S_FWAIT: if (mem_ready) begin
            ld_ir      = 1'b1;
            next_state = S_EXEC1;
         end
         S_EXEC1: begin
            case (opc)
               OP_MV: begin
                  wr_rx      = 1'b1;
                  wsel       = imm_m ? WS_IMM : WS_REG;
                  Done       = 1'b1;
                  next_state = S_FETCH;
               end
               OP_MVT_B: begin
                  if (imm_m) begin
                     wr_rx      = 1'b1;
                     wsel       = WS_MVT;
                     Done       = 1'b1;
                     next_state = S_FETCH;
                  end else if (br_taken) begin
                     ld_g_br    = 1'b1;
                     wr_link    = (rx == COND_BL);
                     next_state = S_EXEC2;
                  end else begin
                     Done       = 1'b1;
                     next_state = S_FETCH;
                  end
               end
               OP_ADD, OP_SUB, OP_AND: begin
                  ld_a       = 1'b1;
                  next_state = S_EXEC2;
               end
               OP_LD: begin
                  ld_addr_ry = 1'b1;
                  next_state = S_MWAIT;
               end
               OP_ST: begin
                  ld_addr_ry = 1'b1;
                  ld_dout    = 1'b1;
                  set_w      = 1'b1;
                  next_state = S_MWAIT;
               end
               default: begin
                  Done       = 1'b1;
                  next_state = S_FETCH;
               end
            endcase
         end
         S_EXEC2: begin
            if (is_alu) begin
               ld_g_alu   = 1'b1;
               ld_flags   = 1'b1;
               next_state = S_EXEC3;
            end else begin
               pc_load_g  = 1'b1;
               Done       = 1'b1;
               next_state = S_FETCH;
            end
         end
         S_EXEC3: begin
            wr_rx      = 1'b1;
            wsel       = WS_G;
            Done       = 1'b1;
            next_state = S_FETCH;
         end
         S_MWAIT: if (mem_ready) begin
            Done       = 1'b1;
            next_state = S_FETCH;
            if (opc == OP_LD) begin
               wr_rx = 1'b1;
               wsel  = WS_DIN;
            end else begin
               clr_w = 1'b1;
            end
         end
         default: next_state = S_FETCH;
      endcase
   end

   // Register-file writes come after the pc increment so a write to r7 wins
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         for (int i = 0; i < 7; i++) r[i] <= '0;
         r[7] <= DATA_W'(RESET_PC);
         a_q  <= '0;
         g_q  <= '0;
         ir   <= '0;
         c_q  <= 1'b0;
         n_q  <= 1'b0;
         z_q  <= 1'b0;
         ADDR <= '0;
         DOUT <= '0;
         W    <= 1'b0;
      end else begin
         if (pc_inc)    r[7] <= r[7] + DATA_W'(1);
         if (pc_load_g) r[7] <= g_q;
         if (wr_link)   r[6] <= r[7];
         if (wr_rx)     r[rx] <= wdata;
         if (ld_ir)     ir <= DIN[15:0];
         if (ld_a)      a_q <= r[rx];
         if (ld_g_br)   g_q <= r[7] + imm;
         if (ld_g_alu)  g_q <= alu_res;
         if (ld_flags) begin
            z_q <= alu_z;
            n_q <= alu_n;
            if (alu_op != ALU_AND) c_q <= alu_c;
         end
         if (ld_addr_pc) ADDR <= ADDR_W'(r[7]);
         if (ld_addr_ry) ADDR <= ADDR_W'(r[ry]);
         if (ld_dout)    DOUT <= r[rx];
         if (set_w)      W <= 1'b1;
         else if (clr_w) W <= 1'b0;
      end
   end

endmodule
